// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//   Two-requester arbiter/sequencer in front of a 32-entry register file.
//   The file has registered reads and a synchronous write.
//   Each grant captures one access: an optional write plus two reads.
//   The access is issued to the register file for one cycle (ISSUE).
//   The read data comes back the following cycle (RESP) with an rvalid pulse.
//   Arbitration is round-robin or fixed priority with a starvation guard for r1.
//
// Ports
//   CLK, reset                  clock; synchronous active-high reset
//   pri_mode                    0 = round-robin, 1 = fixed priority (r0 favoured)
//   rN_req/we/waddr/wdata       requester N access request and write fields
//   rN_raddr1/2                 requester N read addresses
//   rN_gnt                      one-cycle pulse: access captured and issued
//   rN_rvalid, rN_rdata1/2      one-cycle response; data is 0 outside rvalid
//   rf_ReadReg1/2, rf_WriteReg,
//   rf_WriteData, rf_RegWrite,
//   rf_priority_mode            register-file port
//   rf_ReadData1/2              register-file read data, valid the cycle after ISSUE
module reg_file_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          pri_mode,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_waddr,
  input  logic [DW-1:0] r0_wdata,
  input  logic [AW-1:0] r0_raddr1,
  input  logic [AW-1:0] r0_raddr2,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_waddr,
  input  logic [DW-1:0] r1_wdata,
  input  logic [AW-1:0] r1_raddr1,
  input  logic [AW-1:0] r1_raddr2,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata1,
  output logic [DW-1:0] r0_rdata2,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata1,
  output logic [DW-1:0] r1_rdata2,
  output logic [AW-1:0] rf_ReadReg1,
  output logic [AW-1:0] rf_ReadReg2,
  output logic [AW-1:0] rf_WriteReg,
  output logic [DW-1:0] rf_WriteData,
  output logic          rf_RegWrite,
  output logic          rf_priority_mode,
  input  logic [DW-1:0] rf_ReadData1,
  input  logic [DW-1:0] rf_ReadData2
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] ra1_q, ra1_d;
  logic [AW-1:0] ra2_q, ra2_d;

  logic arb_en;
  logic win1;
  logic issue;
  logic resp;

  // Next-state, arbitration and capture
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    starve_d = starve_q;
    owner_d  = owner_q;
    we_d     = we_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    ra1_d    = ra1_q;
    ra2_d    = ra2_q;

    arb_en = (state_q != ISSUE) && (r0_req || r1_req);

    // Winner index: 1 means r1.
    if (r0_req && r1_req) begin
      win1 = pri_mode ? (starve_q == SW'(STARVE_MAX)) : rr_ptr_q;
    end else begin
      win1 = r1_req;
    end

    unique case (state_q)
      IDLE:    if (r0_req || r1_req) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = (r0_req || r1_req) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase

    if (arb_en) begin
      owner_d = win1;
      if (r0_req && r1_req && !pri_mode) rr_ptr_d = ~win1;
      // Count only r0 wins that leave r1 waiting; the force point bounds the count.
      if (!win1 && r1_req) begin
        if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);
      end else begin
        starve_d = '0;
      end
      we_d    = win1 ? r1_we     : r0_we;
      waddr_d = win1 ? r1_waddr  : r0_waddr;
      wdata_d = win1 ? r1_wdata  : r0_wdata;
      ra1_d   = win1 ? r1_raddr1 : r0_raddr1;
      ra2_d   = win1 ? r1_raddr2 : r0_raddr2;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      starve_q <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      ra1_q    <= '0;
      ra2_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      ra1_q    <= ra1_d;
      ra2_q    <= ra2_d;
    end
  end

  // Outputs are gated by reset so an in-flight access is dropped in the reset cycle itself.
  always_comb begin
    issue = !reset && (state_q == ISSUE);
    resp  = !reset && (state_q == RESP);

    r0_gnt    = issue && !owner_q;
    r1_gnt    = issue &&  owner_q;
    r0_rvalid = resp  && !owner_q;
    r1_rvalid = resp  &&  owner_q;
    r0_rdata1 = r0_rvalid ? rf_ReadData1 : '0;
    r0_rdata2 = r0_rvalid ? rf_ReadData2 : '0;
    r1_rdata1 = r1_rvalid ? rf_ReadData1 : '0;
    r1_rdata2 = r1_rvalid ? rf_ReadData2 : '0;

    rf_ReadReg1      = reset ? '0 : ra1_q;
    rf_ReadReg2      = reset ? '0 : ra2_q;
    rf_WriteReg      = reset ? '0 : waddr_q;
    rf_WriteData     = reset ? '0 : wdata_q;
    rf_RegWrite      = issue && we_q;
    rf_priority_mode = 1'b0;
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed testbench for reg_file_arbiter with a behavioural 32x32 register file.
// The register file has registered reads and a write that lands at the same edge.
// A same-cycle read therefore returns the old value.
module tb_reg_file_arbiter;

  logic        CLK;
  logic        reset;
  logic        pri_mode;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [4:0]  r0_waddr, r0_raddr1, r0_raddr2, r1_waddr, r1_raddr1, r1_raddr2;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata1, r0_rdata2, r1_rdata1, r1_rdata2;
  logic [4:0]  rf_ReadReg1, rf_ReadReg2, rf_WriteReg;
  logic [31:0] rf_WriteData;
  logic        rf_RegWrite, rf_priority_mode;
  logic [31:0] rf_ReadData1, rf_ReadData2;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mem [32] = '{default: 32'h0};

  reg_file_arbiter #(.DW(32), .AW(5), .STARVE_MAX(4)) dut (
    .CLK(CLK), .reset(reset), .pri_mode(pri_mode),
    .r0_req(r0_req), .r0_we(r0_we), .r0_waddr(r0_waddr), .r0_wdata(r0_wdata),
    .r0_raddr1(r0_raddr1), .r0_raddr2(r0_raddr2),
    .r1_req(r1_req), .r1_we(r1_we), .r1_waddr(r1_waddr), .r1_wdata(r1_wdata),
    .r1_raddr1(r1_raddr1), .r1_raddr2(r1_raddr2),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata1(r0_rdata1), .r0_rdata2(r0_rdata2),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata1(r1_rdata1), .r1_rdata2(r1_rdata2),
    .rf_ReadReg1(rf_ReadReg1), .rf_ReadReg2(rf_ReadReg2), .rf_WriteReg(rf_WriteReg),
    .rf_WriteData(rf_WriteData), .rf_RegWrite(rf_RegWrite),
    .rf_priority_mode(rf_priority_mode),
    .rf_ReadData1(rf_ReadData1), .rf_ReadData2(rf_ReadData2)
  );

  always @(posedge CLK) begin
    rf_ReadData1 <= mem[rf_ReadReg1];
    rf_ReadData2 <= mem[rf_ReadReg2];
    if (rf_RegWrite) mem[rf_WriteReg] <= rf_WriteData;
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated access from idle: wait for the grant, then check the response.
  task automatic do_access(input bit n, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2, input string tag);
    int k;
    if (n) begin
      r1_we = we; r1_waddr = wa; r1_wdata = wd; r1_raddr1 = a1; r1_raddr2 = a2; r1_req = 1'b1;
    end else begin
      r0_we = we; r0_waddr = wa; r0_wdata = wd; r0_raddr1 = a1; r0_raddr2 = a2; r0_req = 1'b1;
    end
    k = 0;
    tick;
    while (!(n ? r1_gnt : r0_gnt) && k < 8) begin
      tick;
      k++;
    end
    chk({tag, "_gnt"}, {31'b0, (n ? r1_gnt : r0_gnt)}, 32'd1);
    chk({tag, "_regwrite"}, {31'b0, rf_RegWrite}, {31'b0, we});
    r0_req = 1'b0;
    r1_req = 1'b0;
    tick;
    chk({tag, "_rvalid"}, {31'b0, (n ? r1_rvalid : r0_rvalid)}, 32'd1);
    chk({tag, "_other_rvalid"}, {31'b0, (n ? r0_rvalid : r1_rvalid)}, 32'd0);
    chk({tag, "_rdata1"}, n ? r1_rdata1 : r0_rdata1, e1);
    chk({tag, "_rdata2"}, n ? r1_rdata2 : r0_rdata2, e2);
    chk({tag, "_other_rdata1"}, n ? r0_rdata1 : r1_rdata1, 32'd0);
    tick;
  endtask

  // Both requesters held; pat[i] is the expected owner of the i-th grant.
  task automatic run_both(input int cnt, input logic [15:0] pat, input string tag);
    r0_we = 1'b0; r0_raddr1 = 5'd1; r0_raddr2 = 5'd2;
    r1_we = 1'b0; r1_raddr1 = 5'd1; r1_raddr2 = 5'd2;
    r0_req = 1'b1;
    r1_req = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      tick;
      chk($sformatf("%s_g0_%0d", tag, i), {31'b0, r0_gnt}, {31'b0, ~pat[i]});
      chk($sformatf("%s_g1_%0d", tag, i), {31'b0, r1_gnt}, {31'b0, pat[i]});
      if (i == cnt - 1) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
      tick;
      chk($sformatf("%s_gap_%0d", tag, i), {31'b0, (r0_gnt | r1_gnt)}, 32'd0);
      chk($sformatf("%s_rv1_%0d", tag, i), {31'b0, r1_rvalid}, {31'b0, pat[i]});
    end
    tick;
  endtask

  initial begin
    reset = 1'b1; pri_mode = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_waddr = '0; r0_wdata = '0; r0_raddr1 = '0; r0_raddr2 = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_waddr = '0; r1_wdata = '0; r1_raddr1 = '0; r1_raddr2 = '0;

    // Reset held with a pending r0 write
    r0_we = 1'b1; r0_waddr = 5'd3; r0_wdata = 32'h55; r0_raddr1 = 5'd3; r0_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_gnt0", {31'b0, r0_gnt}, 32'd0);
      chk("rst_regwrite", {31'b0, rf_RegWrite}, 32'd0);
      chk("rst_rvalid0", {31'b0, r0_rvalid}, 32'd0);
      chk("rst_writereg", {27'b0, rf_WriteReg}, 32'd0);
    end
    reset = 1'b0;
    tick;
    chk("rel_gnt0", {31'b0, r0_gnt}, 32'd1);
    chk("rel_regwrite", {31'b0, rf_RegWrite}, 32'd1);
    chk("rel_wdata", rf_WriteData, 32'h55);
    chk("rel_pri_mode", {31'b0, rf_priority_mode}, 32'd0);
    r0_req = 1'b0;
    tick;
    chk("rel_rvalid0", {31'b0, r0_rvalid}, 32'd1);
    chk("rel_old_x3", r0_rdata1, 32'h0);
    tick;
    chk("rel_idle_rvalid0", {31'b0, r0_rvalid}, 32'd0);

    // Single write+read, then read-after-write
    do_access(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd3, 32'h0, 32'h55, "single_wr");
    do_access(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, "single_rd");

    // Round-robin: r0,r1,r0,r1,r0,r1
    pri_mode = 1'b0;
    run_both(6, 16'b0000_0000_0010_1010, "rr");

    // Fixed priority with starvation guard: r0 x4, r1, r0 x4, r1
    pri_mode = 1'b1;
    run_both(10, 16'b0000_0010_0001_0000, "starve");

    // Reset during the RESP cycle of an r1 read
    pri_mode = 1'b0;
    r1_we = 1'b0; r1_raddr1 = 5'd5; r1_raddr2 = 5'd0; r1_req = 1'b1;
    tick;
    chk("mid_gnt1", {31'b0, r1_gnt}, 32'd1);
    r1_req = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    chk("mid_rvalid1", {31'b0, r1_rvalid}, 32'd0);
    chk("mid_rdata1", r1_rdata1, 32'h0);
    tick;
    chk("mid_rst_rvalid1", {31'b0, r1_rvalid}, 32'd0);
    reset = 1'b0;
    r0_raddr1 = 5'd5; r0_we = 1'b0; r0_req = 1'b1; r1_req = 1'b1;
    tick;
    chk("mid_next_gnt0", {31'b0, r0_gnt}, 32'd1);
    chk("mid_next_gnt1", {31'b0, r1_gnt}, 32'd0);
    r0_req = 1'b0;
    tick;
    chk("mid_next_rdata0", r0_rdata1, 32'hDEADBEEF);
    tick;
    chk("mid_then_gnt1", {31'b0, r1_gnt}, 32'd1);
    r1_req = 1'b0;
    tick;
    tick;

    // Withdrawn request is never served; write from r0 seen by r1
    r1_req = 1'b1;
    #2;
    r1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wd_gnt1", {31'b0, r1_gnt}, 32'd0);
      chk("wd_gnt0", {31'b0, r0_gnt}, 32'd0);
    end
    do_access(1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 32'h0, 32'h0, "cross_wr");
    do_access(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 32'h11, 32'hDEADBEEF, "cross_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
